// File: rtl/drum_pkg.sv
// drum_pkg: shared types and default widths for the DRUM product accumulator.
//
// Contents
//   DRUM_PROD_W       default product width (DRUM multiplier output r)
//   DRUM_ACC_W        default accumulator width
//   DRUM_MAX_LEN      default maximum products per packet
//   drum_acc_state_t  accumulator FSM state encoding
package drum_pkg;

  localparam int DRUM_PROD_W  = 32;
  localparam int DRUM_ACC_W   = 40;
  localparam int DRUM_MAX_LEN = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } drum_acc_state_t;

endpackage

// File: rtl/drum_acc_add.sv
// drum_acc_add: combinational ACC_W-bit unsigned adder for the product accumulator.
//
// The carry is computed at ACC_W+1 bits. The build-time macro DRUM_ACC_SAT_EN
// selects the behaviour on carry out:
//   defined   : sum clamps to 2^ACC_W-1
//   undefined : sum wraps modulo 2^ACC_W
// Keeping the clamp here leaves the FSM in drum_dot_accum identical in both builds.
//
// Ports
//   a      in   ACC_W   running accumulator value (0 at packet start)
//   b      in   PROD_W  incoming product, zero-extended
//   sum    out  ACC_W   next accumulator value
//   carry  out  1       carry out of the ACC_W-bit addition
module drum_acc_add
  import drum_pkg::*;
#(
  parameter int PROD_W = DRUM_PROD_W,
  parameter int ACC_W  = DRUM_ACC_W
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, a} + (ACC_W+1)'(b);
  assign carry = full[ACC_W];

`ifdef DRUM_ACC_SAT_EN
  // Once clamped, any further nonzero product carries again and re-clamps,
  // so the value stays at full scale for the rest of the packet without extra state.
  assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/drum_dot_accum.sv
// drum_dot_accum: streaming accumulator behind the 16x16 DRUM multiplier.
// Sums one packet of products and presents sum / element count / overflow
// downstream over a valid/ready handshake.
//
// Build option: DRUM_ACC_SAT_EN (see drum_acc_add) selects saturate vs. wrap.
//
// Ports
//   clk         in   1       rising-edge clock
//   rst         in   1       synchronous reset, active-high
//   prod_valid  in   1       product beat valid
//   prod_ready  out  1       block can accept a product
//   prod_data   in   PROD_W  product
//   prod_last   in   1       final product of the packet
//   acc_valid   out  1       result valid
//   acc_ready   in   1       downstream accepts the result
//   acc_data    out  ACC_W   packet sum
//   acc_count   out  CNT_W   number of products summed
//   acc_ovf     out  1       sticky carry-out flag for the packet
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no packet open; next beat starts a new sum
// ACCUM | packet open; beats add into the running sum
// HOLD  | result presented (acc_valid=1); input stalled until acc_ready
module drum_dot_accum
  import drum_pkg::*;
#(
  parameter int PROD_W  = DRUM_PROD_W,
  parameter int ACC_W   = DRUM_ACC_W,
  parameter int MAX_LEN = DRUM_MAX_LEN,
  localparam int CNT_W  = $clog2(MAX_LEN+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf
);

  drum_acc_state_t  state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             valid_q;

  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic [CNT_W-1:0] cnt_next;
  logic             beat;
  logic             close;

  // Ready is a decode of the state register; gating with rst keeps it low
  // in the reset cycle and high from the first IDLE cycle after reset.
  assign prod_ready = (state != HOLD) & ~rst;
  assign beat       = prod_valid & prod_ready;

  // A new packet starts from zero so the same adder serves both IDLE and ACCUM.
  assign add_a    = (state == IDLE) ? '0 : acc;
  assign cnt_next = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
  assign close    = prod_last | (cnt_next == CNT_W'(MAX_LEN));

  drum_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .a     (add_a),
    .b     (prod_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (beat) begin
            acc <= add_sum;
            cnt <= cnt_next;
            // The flag restarts with each packet and is sticky within it.
            ovf <= add_carry | (ovf & (state == ACCUM));
            if (close) begin
              state   <= HOLD;
              valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign acc_valid = valid_q;
  assign acc_data  = acc;
  assign acc_count = cnt;
  assign acc_ovf   = ovf;

endmodule
